// File: rtl/chunked_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : chunked_serial_adder
// Brief    : Multi-cycle WIDTH-bit adder that processes CHUNK bits per clock,
//            LSB chunk first. It keeps a registered carry between chunks and
//            uses a start/busy/done handshake.
// Options  : define CHUNKED_ADDER_SUB_EN to add a 'sub' input, which selects
//            a - b.
// Revision : 1.0 - initial release
// ============================================================================
module chunked_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CHUNKED_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int c_n  = WIDTH / CHUNK;
  localparam int c_cw = (c_n > 1) ? $clog2(c_n) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic               r_carry;
  logic [c_cw-1:0]    r_cnt;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               w_accept;
  logic               w_last;
  logic [CHUNK:0]     w_chunk_sum;
  logic [WIDTH-1:0]   w_b_in;
  logic               w_carry_in;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_cnt == c_cw'(c_n - 1));

  // One CHUNK-wide slice of the ripple, with the carry taken from the previous edge
  assign w_chunk_sum = {1'b0, r_a_sh[CHUNK-1:0]}
                     + {1'b0, r_b_sh[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, r_carry};

`ifdef CHUNKED_ADDER_SUB_EN
  // Subtraction is a + ~b + 1. cin is deliberately ignored in this mode.
  assign w_b_in     = sub ? ~b : b;
  assign w_carry_in = sub ? 1'b1 : cin;
`else
  assign w_b_in     = b;
  assign w_carry_in = cin;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: the DONE state lasts exactly one cycle, and start is ignored outside IDLE
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_next_state = S_RUN;
      S_RUN:   if (w_last) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath: latch the operands on accept, then retire one chunk per RUN edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a_sh  <= a;
      r_b_sh  <= w_b_in;
      r_carry <= w_carry_in;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_sum[r_cnt*CHUNK +: CHUNK] <= w_chunk_sum[CHUNK-1:0];
      r_carry <= w_chunk_sum[CHUNK];
      r_a_sh  <= r_a_sh >> CHUNK;
      r_b_sh  <= r_b_sh >> CHUNK;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_cout <= w_chunk_sum[CHUNK];
      end
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule
`default_nettype wire
